// File: rtl/op_sequencer.sv
// -----------------------------------------------------------------------------
// op_sequencer
//
// Purpose:
//   Command front end for the training controller. Host words arrive on a
//   valid/ready stream and are buffered in a small FIFO. A sequencer FSM pops
//   header words, decodes them, and drives the controller's operation, in_data
//   and enable inputs. All controller-facing outputs are registered.
//
//   Write commands (mode 2) stream LEN+1 payload words, one per enabled cycle.
//   Calc commands (mode 1) hold the operation with enable high for CALC_CYCLES
//   cycles. Every command ends with one NOP cycle (op 0, data 0, enable 1) so
//   the controller re-arms.
//
// Header word layout:
//   [3:0]   mode  (0 NOP, 1 calc, 2 write, anything else is illegal)
//   [22:4]  passed through to op_out unchanged
//   [31:23] LEN, payload count minus 1 (write only); forced to 0 on op_out
//
// Parameters:
//   DEPTH        input FIFO depth in words (power of 2, >= 2)
//   CALC_CYCLES  cycles a calc operation is held with enable high (>= 1)
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   s_valid     host word valid
//   s_ready     FIFO has room; a word is accepted when s_valid && s_ready
//   s_data      host word (header or payload)
//   op_out      operation to the controller
//   data_out    in_data to the controller
//   ctl_enable  enable to the controller
//   busy        FSM not idle, or FIFO not empty
//   err         sticky illegal-mode flag, cleared only by reset
//   cmd_count   (only with OPSEQ_CMD_COUNT_EN) completed commands, wraps
//
// Configuration:
//   OPSEQ_CMD_COUNT_EN  when defined, adds the 16-bit cmd_count output which
//                       increments once per DRAIN cycle.
// -----------------------------------------------------------------------------
module op_sequencer #(
  parameter int DEPTH       = 16,
  parameter int CALC_CYCLES = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic [31:0] op_out,
  output logic [31:0] data_out,
  output logic        ctl_enable,
  output logic        busy,
  output logic        err
`ifdef OPSEQ_CMD_COUNT_EN
  ,
  output logic [15:0] cmd_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CALC_LAST = CW'(CALC_CYCLES - 1);
  localparam logic [CW-1:0] CALC_ONE  = CW'(1);

  // WEND is the cycle the final payload word is on the outputs; DRAIN is the
  // cycle the NOP is on the outputs.
  typedef enum logic [2:0] {
    IDLE,
    CALC,
    WRITE,
    WEND,
    DRAIN
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          sReady_q;
  logic          push;
  logic          pop;
  logic [31:0]   head;

  // ---------------------------------------------------------------------------
  // Sequencer state and registered outputs
  // ---------------------------------------------------------------------------
  state_e        state_q;
  logic [31:0]   op_q;
  logic [31:0]   data_q;
  logic          en_q;
  logic          err_q;
  logic [CW-1:0] calcCnt_q;
  logic [8:0]    remain_q;

  assign push = s_valid && sReady_q;
  assign head = mem_q[rdPtr_q];

  // The FSM only consumes words while it is looking for a header (IDLE, and
  // DRAIN which behaves as IDLE for decoding) or streaming write payload.
  always_comb begin
    pop = 1'b0;
    if (count_q != '0) begin
      if (state_q == IDLE || state_q == DRAIN || state_q == WRITE) begin
        pop = 1'b1;
      end
    end
  end

  // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array has no reset; stale contents are never read because the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= s_data;
    end
  end

  // s_ready is registered from the next occupancy so it is low during reset
  // and rises the cycle after reset is released. A full FIFO refuses a push
  // even if a pop happens in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      sReady_q <= 1'b0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + PTR_ONE;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PTR_ONE;
      end
      count_q  <= count_d;
      sReady_q <= (count_d < CNT_DEPTH);
    end
  end

  // Main sequencer. Outputs are loaded on the edge that leaves the deciding
  // cycle, so a header popped in cycle t is visible on op_out in cycle t+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
      calcCnt_q <= '0;
      remain_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DRAIN: begin
          en_q    <= 1'b0;
          state_q <= IDLE;
          if (count_q != '0) begin
            case (head[3:0])
              4'd0: begin
              end
              4'd1: begin
                state_q   <= CALC;
                op_q      <= {9'd0, head[22:0]};
                en_q      <= 1'b1;
                calcCnt_q <= CALC_LAST;
              end
              4'd2: begin
                state_q  <= WRITE;
                op_q     <= {9'd0, head[22:0]};
                remain_q <= head[31:23];
              end
              default: begin
                err_q <= 1'b1;
              end
            endcase
          end
        end

        // The enable is already high for the first held cycle; when the
        // counter reaches zero the last held cycle is on the outputs, so the
        // NOP is loaded directly.
        CALC: begin
          if (calcCnt_q == '0) begin
            state_q <= DRAIN;
            op_q    <= '0;
            data_q  <= '0;
            en_q    <= 1'b1;
          end else begin
            calcCnt_q <= calcCnt_q - CALC_ONE;
          end
        end

        // Payload words are issued as they arrive; an empty FIFO stalls with
        // the enable low and op/data holding their last values.
        WRITE: begin
          if (count_q != '0) begin
            data_q <= head;
            en_q   <= 1'b1;
            if (remain_q == '0) begin
              state_q <= WEND;
            end else begin
              remain_q <= remain_q - 9'd1;
            end
          end else begin
            en_q <= 1'b0;
          end
        end

        WEND: begin
          state_q <= DRAIN;
          op_q    <= '0;
          data_q  <= '0;
          en_q    <= 1'b1;
        end

        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef OPSEQ_CMD_COUNT_EN
  logic [15:0] cmdCount_q;

  // One DRAIN cycle closes every calc or write command; NOP and illegal
  // headers never reach DRAIN and so are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmdCount_q <= '0;
    end else if (state_q == DRAIN) begin
      cmdCount_q <= cmdCount_q + 16'd1;
    end
  end

  assign cmd_count = cmdCount_q;
`endif

  assign s_ready    = sReady_q;
  assign op_out     = op_q;
  assign data_out   = data_q;
  assign ctl_enable = en_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_op_sequencer
//
// Directed testbench for op_sequencer (DEPTH 16, CALC_CYCLES 80). A monitor
// records op_out/data_out on every enabled cycle; the directed steps then
// compare the record against hand-computed command sequences.
// -----------------------------------------------------------------------------
module tb_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [31:0] op_out;
  logic [31:0] data_out;
  logic        ctl_enable;
  logic        busy;
  logic        err;
`ifdef OPSEQ_CMD_COUNT_EN
  logic [15:0] cmd_count;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] recOp[$];
  logic [31:0] recData[$];
  int          recCyc[$];

  op_sequencer #(
    .DEPTH      (16),
    .CALC_CYCLES(80)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .op_out    (op_out),
    .data_out  (data_out),
    .ctl_enable(ctl_enable),
    .busy      (busy),
    .err       (err)
`ifdef OPSEQ_CMD_COUNT_EN
    ,
    .cmd_count (cmd_count)
`endif
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Cycle stamp for the monitor.
  always @(posedge clk) cyc++;

  // Capture every cycle the controller is enabled, away from the active edge.
  always @(negedge clk) begin
    if (ctl_enable === 1'b1) begin
      recOp.push_back(op_out);
      recData.push_back(data_out);
      recCyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearRec();
    recOp.delete();
    recData.delete();
    recCyc.delete();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Offer one word and hold it until the FIFO accepts it (bounded).
  task automatic applyStimulus(input logic [31:0] word);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = word;
    while (s_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checkOutput("push_timeout", 32'(s_ready), 32'd1);
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] seq [21];
    logic [31:0] wdat [4];
    int          bad;
    int          idx;
    int          n;
    int          idxAt40;
    logic        rdy;
    logic        rdy40;

    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    idxAt40 = -1;
    rdy40   = 1'b1;

    // Reset state.
    tick();
    tick();
    checkOutput("rst_op",    op_out,            32'd0);
    checkOutput("rst_data",  data_out,          32'd0);
    checkOutput("rst_en",    32'(ctl_enable),   32'd0);
    checkOutput("rst_busy",  32'(busy),         32'd0);
    checkOutput("rst_err",   32'(err),          32'd0);
    checkOutput("rst_ready", 32'(s_ready),      32'd0);
    reset = 1'b0;
    tick();
    checkOutput("ready_after_rst", 32'(s_ready), 32'd1);

    // Write: mode 2, addr 8, LEN 3, four payload words then a NOP.
    $display("[TB] write burst");
    clearRec();
    wdat[0] = 32'h1111_0001;
    wdat[1] = 32'h2222_0002;
    wdat[2] = 32'h3333_0003;
    wdat[3] = 32'h4444_0004;
    applyStimulus(32'h0180_0082);
    for (int i = 0; i < 4; i++) applyStimulus(wdat[i]);
    waitIdle("wr_idle");
    checkOutput("wr_count", 32'(recOp.size()), 32'd5);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wr_op%0d", i),   recOp[i],   32'h0000_0082);
      checkOutput($sformatf("wr_data%0d", i), recData[i], wdat[i]);
    end
    checkOutput("wr_drain_op",   recOp[4],   32'd0);
    checkOutput("wr_drain_data", recData[4], 32'd0);
    checkOutput("wr_contig", 32'(recCyc[4] - recCyc[0]), 32'd4);
`ifdef OPSEQ_CMD_COUNT_EN
    checkOutput("cnt_after_wr", 32'(cmd_count), 32'd1);
`endif

    // Calc: op held for exactly 80 enabled cycles, then one NOP.
    $display("[TB] calc hold");
    clearRec();
    applyStimulus(32'h0001_0011);
    waitIdle("calc_idle");
    checkOutput("calc_count", 32'(recOp.size()), 32'd81);
    bad = 0;
    for (int i = 0; i < 80; i++) if (recOp[i] !== 32'h0001_0011) bad++;
    checkOutput("calc_op_held", 32'(bad), 32'd0);
    checkOutput("calc_drain_op", recOp[80], 32'd0);
    checkOutput("calc_contig", 32'(recCyc[80] - recCyc[0]), 32'd80);
`ifdef OPSEQ_CMD_COUNT_EN
    checkOutput("cnt_after_calc", 32'(cmd_count), 32'd2);
`endif

    // Stall: LEN 1, second payload word arrives late.
    $display("[TB] write stall");
    clearRec();
    applyStimulus(32'h0080_0052);
    applyStimulus(32'hBEEF_0000);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("stall_en%0d", i),   32'(ctl_enable), 32'd0);
      checkOutput($sformatf("stall_op%0d", i),   op_out,          32'h0000_0052);
      checkOutput($sformatf("stall_data%0d", i), data_out,        32'hBEEF_0000);
    end
    applyStimulus(32'hBEEF_0001);
    waitIdle("stall_idle");
    checkOutput("stall_count", 32'(recOp.size()), 32'd3);
    checkOutput("stall_d0",    recData[0], 32'hBEEF_0000);
    checkOutput("stall_d1",    recData[1], 32'hBEEF_0001);
    checkOutput("stall_op1",   recOp[1],   32'h0000_0052);
    checkOutput("stall_drain", recOp[2],   32'd0);
`ifdef OPSEQ_CMD_COUNT_EN
    checkOutput("cnt_after_stall", 32'(cmd_count), 32'd3);
`endif

    // Backpressure: s_valid held high through a calc; the FIFO fills with a
    // write header plus 15 payload words, then trailing NOPs wait.
    $display("[TB] backpressure");
    clearRec();
    seq[0] = 32'h0001_0011;
    seq[1] = 32'h0700_0032;
    for (int k = 0; k < 15; k++) seq[2 + k] = 32'hA500_0000 + 32'(k);
    for (int k = 0; k < 4; k++)  seq[17 + k] = 32'h0000_0100 + 32'(k * 16);
    idx = 0;
    n   = 0;
    while (idx < 21 && n < 600) begin
      rdy     = s_ready;
      s_valid = 1'b1;
      s_data  = seq[idx];
      if (n == 40) begin
        rdy40   = s_ready;
        idxAt40 = idx;
      end
      tick();
      if (rdy) idx++;
      n++;
    end
    s_valid = 1'b0;
    checkOutput("bp_all_sent", 32'(idx), 32'd21);
    checkOutput("bp_ready_low", 32'(rdy40), 32'd0);
    checkOutput("bp_buffered", 32'(idxAt40), 32'd17);
    waitIdle("bp_idle");
    checkOutput("bp_count", 32'(recOp.size()), 32'd97);
    bad = 0;
    for (int i = 0; i < 80; i++) if (recOp[i] !== 32'h0001_0011) bad++;
    checkOutput("bp_calc_held", 32'(bad), 32'd0);
    checkOutput("bp_calc_drain", recOp[80], 32'd0);
    for (int k = 0; k < 15; k++) begin
      checkOutput($sformatf("bp_data%0d", k), recData[81 + k], 32'hA500_0000 + 32'(k));
    end
    checkOutput("bp_wr_op", recOp[81], 32'h0000_0032);
    checkOutput("bp_wr_drain", recOp[96], 32'd0);
    checkOutput("bp_err", 32'(err), 32'd0);
`ifdef OPSEQ_CMD_COUNT_EN
    checkOutput("cnt_after_bp", 32'(cmd_count), 32'd5);
`endif

    // Illegal mode sets a sticky err and produces no enabled cycle.
    $display("[TB] illegal mode");
    clearRec();
    applyStimulus(32'h0000_0007);
    waitIdle("ill_idle");
    tick();
    checkOutput("ill_err", 32'(err), 32'd1);
    checkOutput("ill_no_en", 32'(recOp.size()), 32'd0);
    applyStimulus(32'h0000_0012);
    applyStimulus(32'h0000_CAFE);
    waitIdle("ill_next_idle");
    checkOutput("ill_next_count", 32'(recOp.size()), 32'd2);
    checkOutput("ill_next_op",    recOp[0],   32'h0000_0012);
    checkOutput("ill_next_data",  recData[0], 32'h0000_CAFE);
    checkOutput("ill_next_drain", recOp[1],   32'd0);
    checkOutput("ill_err_sticky", 32'(err), 32'd1);

    // Reset in cycle 40 of a calc with words still buffered.
    $display("[TB] reset mid calc");
    applyStimulus(32'h0001_0011);
    n = 0;
    while (ctl_enable !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("rc_start", 32'(ctl_enable), 32'd1);
    applyStimulus(32'h0000_0022);
    applyStimulus(32'h0000_0000);
    repeat (37) tick();
    checkOutput("rc_en40", 32'(ctl_enable), 32'd1);
    checkOutput("rc_op40", op_out, 32'h0001_0011);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clearRec();
    checkOutput("rc_op",   op_out,          32'd0);
    checkOutput("rc_data", data_out,        32'd0);
    checkOutput("rc_en",   32'(ctl_enable), 32'd0);
    checkOutput("rc_busy", 32'(busy),       32'd0);
    checkOutput("rc_err",  32'(err),        32'd0);
`ifdef OPSEQ_CMD_COUNT_EN
    checkOutput("rc_cnt", 32'(cmd_count), 32'd0);
`endif
    tick();
    checkOutput("rc_ready", 32'(s_ready), 32'd1);
    repeat (5) tick();
    checkOutput("rc_flushed", 32'(recOp.size()), 32'd0);
    checkOutput("rc_busy_later", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
